// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode seven-segment scanner. The inputs are captured once per frame,
// and one hex digit at a time is driven onto the shared active-low segment lines.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  decimal_point,
  input  logic        blank_leading,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_p0;
  logic [1:0]       idx_p0;
  logic             first_cycle;
  logic [15:0]      value_p0;
  logic [3:0]       dpt_p0;
  logic             blank_p0;
  logic             tick;
  logic             load;
  logic [3:0]       blank_mask;
  logic [3:0]       nib;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A digit is blank only if it and every digit to its left are zero with no decimal point lit.
  function automatic logic [3:0] blank_digits(input logic [15:0] v, input logic [3:0] d,
                                              input logic b);
    logic [3:0] m;
    m[3] = b && (v[15:12] == 4'h0) && !d[3];
    m[2] = m[3] && (v[11:8] == 4'h0) && !d[2];
    m[1] = m[2] && (v[7:4] == 4'h0) && !d[1];
    m[0] = 1'b0;
    return m;
  endfunction

  always_comb begin
    tick       = (cnt_p0 == CNT_MAX);
    load       = (tick && (idx_p0 == 2'd3)) || first_cycle;
    nib        = value_p0[{idx_p0, 2'b00} +: 4];
    blank_mask = blank_digits(value_p0, dpt_p0, blank_p0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0        <= '0;
      idx_p0        <= 2'd0;
      first_cycle   <= 1'b1;
      value_p0      <= '0;
      dpt_p0        <= '0;
      blank_p0      <= 1'b0;
      an            <= 4'b1111;
      seg           <= 7'h7F;
      dp            <= 1'b1;
      frame_done    <= 1'b0;
    end else begin
      // Stage p0: scan counters and frame snapshot. The counters hold during the
      // initial load cycle, so the first frame is as long as every later frame.
      first_cycle <= 1'b0;
      frame_done  <= load;
      if (!first_cycle) begin
        cnt_p0 <= tick ? '0 : cnt_p0 + 1'b1;
        if (tick) idx_p0 <= idx_p0 + 2'd1;
      end
      if (load) begin
        value_p0 <= value;
        dpt_p0   <= decimal_point;
        blank_p0 <= blank_leading;
      end
      // Stage p1: registered digit drive, one cycle behind the index and snapshot.
      if (first_cycle || blank_mask[idx_p0]) begin
        an  <= 4'b1111;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx_p0);
        seg <= hex_to_seg(nib);
        dp  <= ~dpt_p0[idx_p0];
      end
    end
  end

endmodule
